simd_lane_pipe: RTL and testbench

Parametrised, fully pipelined packed-integer SIMD unit for the integer execution cluster. It takes 68-bit operands in the codebase's integer register format and performs per-lane add/sub, saturating add/sub, min/max, compare and bitwise operations. Element size is selectable per operation (8/16/32/64 bits), with signed or unsigned interpretation. The result is driven onto the shared 68-bit result bus after a configurable latency, together with an op tag and a saturation flag. In-flight operations can be killed by a flush.

---
 rtl/simd_lane_pipe.sv | 189 ++++++++++++++++++
 tb/tb_simd_lane_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_lane_pipe.sv
// simd_lane_pipe: packed-integer SIMD ALU (8/16/32/64-bit lanes) followed by
// a LAT-deep result pipeline with flush. The ALU result is computed from the
// issue-cycle inputs and captured in the first pipeline stage.

`ifndef PTYPE_INT_VAL
`define PTYPE_INT_VAL 1
`endif

module simd_lane_pipe #(
   parameter int LAT   = 2,
   parameter int TAG_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [6:0]       op,
   input  logic [67:0]      A,
   input  logic [67:0]      B,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             flush,
   output logic [67:0]      res,
   output logic             res_en,
   output logic [TAG_W-1:0] tag_out,
   output logic             sat
);

   localparam logic [1:0] PTYPE_INT = 2'(`PTYPE_INT_VAL);

   logic [3:0]  func;
   logic [1:0]  size;
   logic        sgn;
   logic [63:0] a;
   logic [63:0] b;
   logic        unused;

   assign func   = op[3:0];
   assign size   = op[5:4];
   assign sgn    = op[6];
   assign a      = {A[64:33], A[31:0]};
   assign b      = {B[64:33], B[31:0]};
   assign unused = ^{A[67:65], A[32], B[67:65], B[32]};

   logic        sub_mode;
   logic [2:0]  mask;
   logic [8:0]  carry;
   logic [63:0] sum;

   // Segmented 64-bit adder built from byte slices; the carry into a byte is
   // replaced by the lane carry-in (1 for subtract) at every lane boundary.
   always_comb begin
      sub_mode = func inside {4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
      case (size)
         2'd0:    mask = 3'd0;
         2'd1:    mask = 3'd1;
         2'd2:    mask = 3'd3;
         default: mask = 3'd7;
      endcase
      carry = '0;
      sum   = '0;
      for (int i = 0; i < 8; i++) begin
         {carry[i+1], sum[8*i +: 8]} = {1'b0, a[8*i +: 8]}
            + {1'b0, (sub_mode ? ~b[8*i +: 8] : b[8*i +: 8])}
            + {8'd0, (((3'(i) & mask) == 3'd0) ? sub_mode : carry[i])};
      end
   end

   logic [2:0]  e;
   int          ei;
   logic        sa;
   logic        sb;
   logic        sr;
   logic        cout;
   logic        ovf_s;
   logic        ovf_u;
   logic        clamp;
   logic        lt;
   logic        eq;
   logic [7:0]  ab;
   logic [7:0]  bb;
   logic [7:0]  sumb;
   logic [7:0]  clampb;
   logic [7:0]  rb;
   logic [63:0] r_comb;
   logic        sat_comb;

   // Per-byte result selection; lane-wide flags are taken from the top byte
   // of the lane that each byte belongs to.
   always_comb begin
      r_comb   = '0;
      sat_comb = 1'b0;
      e        = '0;
      ei       = 0;
      sa       = 1'b0;
      sb       = 1'b0;
      sr       = 1'b0;
      cout     = 1'b0;
      ovf_s    = 1'b0;
      ovf_u    = 1'b0;
      clamp    = 1'b0;
      lt       = 1'b0;
      eq       = 1'b0;
      ab       = '0;
      bb       = '0;
      sumb     = '0;
      clampb   = '0;
      rb       = '0;
      for (int i = 0; i < 8; i++) begin
         e     = 3'(i) | mask;
         ei    = int'(e);
         sa    = a[8*ei+7];
         sb    = b[8*ei+7];
         sr    = sum[8*ei+7];
         cout  = carry[ei+1];
         ovf_s = sub_mode ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
         ovf_u = sub_mode ? ~cout : cout;
         clamp = sgn ? ovf_s : ovf_u;
         lt    = sgn ? (sr ^ ovf_s) : ~cout;
         eq    = 1'b1;
         for (int j = 0; j < 8; j++) begin
            if (((3'(j) | mask) == e) && (a[8*j +: 8] != b[8*j +: 8])) begin
               eq = 1'b0;
            end
         end
         ab   = a[8*i +: 8];
         bb   = b[8*i +: 8];
         sumb = sum[8*i +: 8];
         if (sgn) begin
            clampb = (ei == i) ? (sa ? 8'h80 : 8'h7F) : (sa ? 8'h00 : 8'hFF);
         end else begin
            clampb = sub_mode ? 8'h00 : 8'hFF;
         end
         case (func)
            4'd0, 4'd1: rb = sumb;
            4'd2, 4'd3: begin
               rb       = clamp ? clampb : sumb;
               sat_comb = sat_comb | clamp;
            end
            4'd4:    rb = lt ? ab : bb;
            4'd5:    rb = lt ? bb : ab;
            4'd6:    rb = {8{eq}};
            4'd7:    rb = {8{~lt & ~eq}};
            4'd8:    rb = ab & bb;
            4'd9:    rb = ab | bb;
            4'd10:   rb = ab ^ bb;
            4'd11:   rb = ab & ~bb;
            4'd12:   rb = ~(ab | bb);
            4'd13:   rb = ~(ab ^ bb);
            4'd14:   rb = bb;
            default: rb = ~bb;
         endcase
         r_comb[8*i +: 8] = rb;
      end
   end

   logic [LAT-1:0]   valid_q;
   logic [63:0]      data_q [LAT];
   logic             sat_q  [LAT];
   logic [TAG_W-1:0] tag_q  [LAT];

   // Valid bits: reset or flush empties the whole pipe, including this cycle's issue.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid_q <= '0;
      end else begin
         valid_q[0] <= en;
         for (int k = 1; k < LAT; k++) begin
            valid_q[k] <= valid_q[k-1];
         end
      end
   end

   // Payload: stage 0 captures the ALU result, later stages are plain delay.
   always_ff @(posedge clk) begin
      data_q[0] <= r_comb;
      sat_q[0]  <= sat_comb;
      tag_q[0]  <= tag_in;
      for (int k = 1; k < LAT; k++) begin
         data_q[k] <= data_q[k-1];
         sat_q[k]  <= sat_q[k-1];
         tag_q[k]  <= tag_q[k-1];
      end
   end

   assign res_en  = valid_q[LAT-1];
   assign tag_out = res_en ? tag_q[LAT-1] : '0;
   assign sat     = res_en & sat_q[LAT-1];
   assign res     = res_en ? {PTYPE_INT, 1'b0, data_q[LAT-1][63:32], 1'b0, data_q[LAT-1][31:0]} : 'z;

endmodule

// File: tb/tb_simd_lane_pipe.sv
// tb_simd_lane_pipe: drives four simd_lane_pipe instances (LAT=1..4) from one
// stimulus stream and compares them with a lane-arithmetic reference model.

`ifndef PTYPE_INT_VAL
`define PTYPE_INT_VAL 1
`endif

module tb_simd_lane_pipe;

   localparam int         TAG_W     = 9;
   localparam int         HIST      = 4096;
   localparam logic [1:0] PTYPE_INT = 2'(`PTYPE_INT_VAL);

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             flush;
   logic [6:0]       op;
   logic [67:0]      A;
   logic [67:0]      B;
   logic [TAG_W-1:0] tag_in;

   wire  [67:0]      res1, res2, res3, res4;
   logic             res_en1, res_en2, res_en3, res_en4;
   logic [TAG_W-1:0] tag1, tag2, tag3, tag4;
   logic             sat1, sat2, sat3, sat4;

   int total = 0;
   int bad   = 0;

   simd_lane_pipe #(.LAT(1), .TAG_W(TAG_W)) dut1 (
      .clk(clk), .rst(rst), .en(en), .op(op), .A(A), .B(B), .tag_in(tag_in), .flush(flush),
      .res(res1), .res_en(res_en1), .tag_out(tag1), .sat(sat1));
   simd_lane_pipe #(.LAT(2), .TAG_W(TAG_W)) dut2 (
      .clk(clk), .rst(rst), .en(en), .op(op), .A(A), .B(B), .tag_in(tag_in), .flush(flush),
      .res(res2), .res_en(res_en2), .tag_out(tag2), .sat(sat2));
   simd_lane_pipe #(.LAT(3), .TAG_W(TAG_W)) dut3 (
      .clk(clk), .rst(rst), .en(en), .op(op), .A(A), .B(B), .tag_in(tag_in), .flush(flush),
      .res(res3), .res_en(res_en3), .tag_out(tag3), .sat(sat3));
   simd_lane_pipe #(.LAT(4), .TAG_W(TAG_W)) dut4 (
      .clk(clk), .rst(rst), .en(en), .op(op), .A(A), .B(B), .tag_in(tag_in), .flush(flush),
      .res(res4), .res_en(res_en4), .tag_out(tag4), .sat(sat4));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] r;
      logic        s;
   } ref_t;

   // Lane-by-lane reference using wide signed arithmetic and explicit range limits.
   function automatic ref_t ref_op(input logic [6:0] o, input logic [63:0] a, input logic [63:0] b);
      ref_t               rt;
      int                 w;
      int                 lanes;
      logic signed [67:0] x, y, full, lo, hi, big;
      logic [63:0]        m, ua, ub, lane;
      rt.r  = '0;
      rt.s  = 1'b0;
      w     = 8 << o[5:4];
      lanes = 64 / w;
      case (o[3:0])
         4'd8:  rt.r = a & b;
         4'd9:  rt.r = a | b;
         4'd10: rt.r = a ^ b;
         4'd11: rt.r = a & ~b;
         4'd12: rt.r = ~(a | b);
         4'd13: rt.r = ~(a ^ b);
         4'd14: rt.r = b;
         4'd15: rt.r = ~b;
         default: begin
            big = 68'sd1 <<< w;
            m   = 64'(big - 68'sd1);
            lo  = o[6] ? -(big >>> 1) : 68'sd0;
            hi  = o[6] ? (big >>> 1) - 68'sd1 : big - 68'sd1;
            for (int l = 0; l < lanes; l++) begin
               ua = (a >> (l * w)) & m;
               ub = (b >> (l * w)) & m;
               x  = $signed({4'b0, ua});
               y  = $signed({4'b0, ub});
               if (o[6] && ua[w-1]) x = x - big;
               if (o[6] && ub[w-1]) y = y - big;
               case (o[3:0])
                  4'd0: full = x + y;
                  4'd1: full = x - y;
                  4'd2, 4'd3: begin
                     full = (o[3:0] == 4'd2) ? x + y : x - y;
                     if (full > hi) begin
                        full = hi;
                        rt.s = 1'b1;
                     end else if (full < lo) begin
                        full = lo;
                        rt.s = 1'b1;
                     end
                  end
                  4'd4:    full = (x < y) ? x : y;
                  4'd5:    full = (x > y) ? x : y;
                  4'd6:    full = (x == y) ? -68'sd1 : 68'sd0;
                  default: full = (x > y) ? -68'sd1 : 68'sd0;
               endcase
               lane = 64'(full) & m;
               rt.r = rt.r | (lane << (l * w));
            end
         end
      endcase
      return rt;
   endfunction

   function automatic logic [67:0] packRes(input logic [63:0] r);
      return {PTYPE_INT, 1'b0, r[63:32], 1'b0, r[31:0]};
   endfunction

   function automatic logic [63:0] unpackOp(input logic [67:0] v);
      return {v[64:33], v[31:0]};
   endfunction

   function automatic logic [63:0] randOperand();
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) begin
         case ($urandom_range(0, 5))
            0:       v[8*i +: 8] = 8'h00;
            1:       v[8*i +: 8] = 8'h01;
            2:       v[8*i +: 8] = 8'h7F;
            3:       v[8*i +: 8] = 8'h80;
            4:       v[8*i +: 8] = 8'hFF;
            default: v[8*i +: 8] = 8'($urandom);
         endcase
      end
      return v;
   endfunction

   // History of what each clock edge sampled, plus the model's result for it.
   int               ecount = 0;
   bit               h_en   [HIST];
   bit               h_kill [HIST];
   logic [63:0]      h_r    [HIST];
   bit               h_sat  [HIST];
   logic [TAG_W-1:0] h_tag  [HIST];
   ref_t             rec;

   // Record every edge's inputs with the model's answer.
   always @(posedge clk) begin
      rec = ref_op(op, unpackOp(A), unpackOp(B));
      if (ecount + 1 < HIST) begin
         h_en[ecount+1]   <= en;
         h_kill[ecount+1] <= rst || flush;
         h_r[ecount+1]    <= rec.r;
         h_sat[ecount+1]  <= rec.s;
         h_tag[ecount+1]  <= tag_in;
      end
      ecount <= ecount + 1;
   end

   task automatic checkOutput(input int lat, input logic [67:0] r_act, input logic en_act,
                              input logic [TAG_W-1:0] tag_act, input logic sat_act);
      int          n;
      bit          v;
      bit          ok;
      logic [67:0] r_exp;
      n = ecount - lat + 1;
      v = (n >= 1) && (n < HIST) && h_en[n];
      for (int m = n; m <= ecount && v; m++) begin
         if (m >= 1 && h_kill[m]) v = 1'b0;
      end
      r_exp = v ? packRes(h_r[n]) : '0;
      if (v) begin
         ok = (en_act === 1'b1) && (r_act === r_exp) && (tag_act === h_tag[n]) && (sat_act === h_sat[n]);
      end else begin
         ok = (en_act === 1'b0) && (tag_act === '0) && (sat_act === 1'b0) &&
              ((r_act === 'z) || (r_act === '0));
      end
      total++;
      if (!ok) begin
         bad++;
         $display("[TB] FAIL pipe_lat%0d edge=%0d: got en=%0b res=%h tag=%0d sat=%0b, required en=%0b res=%h tag=%0d sat=%0b",
                  lat, ecount, en_act, r_act, tag_act, sat_act, v, r_exp, v ? h_tag[n] : '0, v ? h_sat[n] : 1'b0);
      end
   endtask

   // Every instance is compared with the model on each falling edge.
   always @(negedge clk) begin
      if (ecount >= 1) begin
         checkOutput(1, res1, res_en1, tag1, sat1);
         checkOutput(2, res2, res_en2, tag2, sat2);
         checkOutput(3, res3, res_en3, tag3, sat3);
         checkOutput(4, res4, res_en4, tag4, sat4);
      end
   end

   task automatic checkValue(input string name, input logic [67:0] act, input logic [67:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic checkIdleRes(input string name, input logic [67:0] act);
      total++;
      if (!((act === 'z) || (act === '0))) begin
         bad++;
         $display("[TB] FAIL %s: got %h, required high-Z", name, act);
      end
   endtask

   task automatic applyStimulus(input bit e, input bit f, input logic [6:0] o,
                                input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] t);
      en     = e;
      flush  = f;
      op     = o;
      A      = {3'($urandom), a[63:32], 1'($urandom), a[31:0]};
      B      = {3'($urandom), b[63:32], 1'($urandom), b[31:0]};
      tag_in = t;
   endtask

   typedef struct {
      logic [6:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] r;
      logic        s;
   } vec_t;

   vec_t vecs[14];

   initial begin
      vecs[0]  = '{{1'b1, 2'd0, 4'd2},  64'h7F7F7F7F7F7F7F7F, 64'h0101010101010101, 64'h7F7F7F7F7F7F7F7F, 1'b1};
      vecs[1]  = '{{1'b1, 2'd0, 4'd0},  64'h7F7F7F7F7F7F7F7F, 64'h0101010101010101, 64'h8080808080808080, 1'b0};
      vecs[2]  = '{{1'b0, 2'd1, 4'd3},  64'h0001000100010001, 64'h0002000200020002, 64'h0000000000000000, 1'b1};
      vecs[3]  = '{{1'b1, 2'd1, 4'd3},  64'h0001000100010001, 64'h0002000200020002, 64'hFFFFFFFFFFFFFFFF, 1'b0};
      vecs[4]  = '{{1'b1, 2'd2, 4'd4},  64'hFFFFFFFF00000005, 64'h0000000100000007, 64'hFFFFFFFF00000005, 1'b0};
      vecs[5]  = '{{1'b0, 2'd2, 4'd4},  64'hFFFFFFFF00000005, 64'h0000000100000007, 64'h0000000100000005, 1'b0};
      vecs[6]  = '{{1'b1, 2'd0, 4'd7},  64'h807F0001807F0001, 64'h0000000000000000, 64'h00FF00FF00FF00FF, 1'b0};
      vecs[7]  = '{{1'b1, 2'd3, 4'd10}, 64'h0123456789ABCDEF, 64'hFFFF0000FFFF0000, 64'hFEDC45677654CDEF, 1'b0};
      vecs[8]  = '{{1'b0, 2'd3, 4'd5},  64'h0000000000000001, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
      vecs[9]  = '{{1'b0, 2'd1, 4'd6},  64'h123456789ABCDEF0, 64'h123400009ABC0000, 64'hFFFF0000FFFF0000, 1'b0};
      vecs[10] = '{{1'b1, 2'd3, 4'd2},  64'h7FFFFFFFFFFFFFFF, 64'h0000000000000001, 64'h7FFFFFFFFFFFFFFF, 1'b1};
      vecs[11] = '{{1'b1, 2'd0, 4'd3},  64'h8080808080808080, 64'h0101010101010101, 64'h8080808080808080, 1'b1};
      vecs[12] = '{{1'b0, 2'd0, 4'd11}, 64'hFF00FF00FF00FF00, 64'hF0F0F0F0F0F0F0F0, 64'h0F000F000F000F00, 1'b0};
      vecs[13] = '{{1'b0, 2'd2, 4'd1},  64'h0000000000000000, 64'h0000000100000001, 64'hFFFFFFFFFFFFFFFF, 1'b0};

      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 7'd0, 64'd0, 64'd0, '0);
      repeat (3) @(posedge clk);
      #1;
      checkValue("reset_res_en", {67'd0, res_en4}, 68'd0);
      checkValue("reset_tag", {59'd0, tag4}, 68'd0);
      checkIdleRes("reset_res", res4);
      rst = 1'b0;

      $display("[TB] table vectors");
      for (int i = 0; i < 14; i++) begin
         applyStimulus(1'b1, 1'b0, vecs[i].op, vecs[i].a, vecs[i].b, TAG_W'(i + 16));
         @(posedge clk);
         #1;
         applyStimulus(1'b0, 1'b0, 7'($urandom), randOperand(), randOperand(), TAG_W'($urandom));
         @(posedge clk);
         @(negedge clk);
         checkValue($sformatf("vec%0d_res", i), res2, packRes(vecs[i].r));
         checkValue($sformatf("vec%0d_en_sat_tag", i), {57'd0, res_en2, sat2, tag2},
                    {57'd0, 1'b1, vecs[i].s, TAG_W'(i + 16)});
         @(posedge clk);
         #1;
      end

      $display("[TB] flush sequence");
      for (int t = 1; t <= 4; t++) begin
         applyStimulus(1'b1, t == 4, 7'($urandom), randOperand(), randOperand(), TAG_W'(t));
         @(posedge clk);
         #1;
      end
      applyStimulus(1'b1, 1'b0, {1'b0, 2'd0, 4'd0}, 64'h0102030405060708, 64'h1010101010101010, TAG_W'(5));
      @(negedge clk);
      checkValue("flush_kill_lat3", {67'd0, res_en3}, 68'd0);
      checkIdleRes("flush_idle_res_lat3", res3);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 7'($urandom), randOperand(), randOperand(), '0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i == 3) begin
            checkValue("after_flush_res", res3, packRes(64'h1112131415161718));
            checkValue("after_flush_tag", {58'd0, res_en3, tag3}, {58'd0, 1'b1, TAG_W'(5)});
         end else begin
            checkValue($sformatf("after_flush_quiet%0d", i), {67'd0, res_en3}, 68'd0);
         end
      end
      @(posedge clk);
      #1;

      $display("[TB] reset with ops in flight");
      applyStimulus(1'b1, 1'b0, 7'($urandom), randOperand(), randOperand(), TAG_W'(20));
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 1'b0, 7'($urandom), randOperand(), randOperand(), TAG_W'(21));
      @(posedge clk);
      #1;
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 7'd0, 64'd0, 64'd0, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkValue($sformatf("rst_kill%0d", i), {64'd0, res_en1, res_en2, res_en3, res_en4}, 68'd0);
      end
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 1'b0, {1'b1, 2'd3, 4'd3}, 64'h8000000000000000, 64'h0000000000000001, TAG_W'(33));
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 7'd0, 64'd0, 64'd0, '0);
      @(negedge clk);
      checkValue("post_rst_lat1_res", res1, packRes(64'h8000000000000000));
      checkValue("post_rst_lat1_flags", {58'd0, sat1, tag1}, {58'd0, 1'b1, TAG_W'(33)});
      repeat (3) @(negedge clk);
      checkValue("post_rst_lat4_res", res4, packRes(64'h8000000000000000));
      checkValue("post_rst_lat4_flags", {57'd0, res_en4, sat4, tag4}, {57'd0, 1'b1, 1'b1, TAG_W'(33)});
      @(posedge clk);
      #1;

      $display("[TB] random traffic");
      for (int c = 0; c < 400; c++) begin
         applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 4,
                       7'($urandom), randOperand(), randOperand(), TAG_W'($urandom));
         rst = ($urandom_range(0, 99) < 2);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 7'd0, 64'd0, 64'd0, '0);
      repeat (6) @(posedge clk);
      @(negedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
